// File: rtl/rvmv_elem_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : rvmv_elem_packer_if
// Brief    : Element-in / packed-word-out handshake bundle for rvmv_elem_packer.
//            The master modport is the side that drives elements in and drains
//            words out. The slave modport is the packer itself.
// Revision : 1.0  initial release
// ============================================================================
interface rvmv_elem_packer_if #(
  parameter int DATA_W = 32
);
  logic [1:0]          ew_i;
  logic                in_valid_i;
  logic                in_ready_o;
  logic [31:0]         in_data_i;
  logic                in_last_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [DATA_W-1:0]   out_data_o;
  logic [DATA_W/4-1:0] out_nmask_o;
  logic                out_last_o;

  modport master (
    output ew_i, in_valid_i, in_data_i, in_last_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_nmask_o, out_last_o
  );

  modport slave (
    input  ew_i, in_valid_i, in_data_i, in_last_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_nmask_o, out_last_o
  );
endinterface
`default_nettype wire

// File: rtl/rvmv_elem_packer.sv
`default_nettype none
// ============================================================================
// Module   : rvmv_elem_packer
// Brief    : Packs 4/8/16/32-bit elements LSB-first into DATA_W-bit words with
//            a per-nibble write mask. There is one accumulator and a one-deep
//            output buffer. Words are emitted when full or on the last element.
//            Optional macro RVMV_PACKER_STATS_EN adds a saturating 16-bit count
//            of output handshakes on stat_words_o.
// Revision : 1.0  initial release
// ============================================================================
module rvmv_elem_packer #(
  parameter int DATA_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  rvmv_elem_packer_if.slave  bus
`ifdef RVMV_PACKER_STATS_EN
  ,
  output logic [15:0]        stat_words_o
`endif
);

  localparam int NIBS  = DATA_W / 4;
  localparam int CNT_W = $clog2(NIBS);
  localparam logic [1:0] C_EW8 = 2'b01;

  // Accumulator
  logic [DATA_W-1:0] acc_data_q,  acc_data_d;
  logic [NIBS-1:0]   acc_nmask_q, acc_nmask_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [1:0]        ew_q,        ew_d;

  // Output buffer
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [NIBS-1:0]   out_nmask_q, out_nmask_d;
  logic              out_last_q,  out_last_d;
  logic              out_valid_q, out_valid_d;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_out_hs;
  logic              w_complete;
  logic [1:0]        w_ew_eff;
  logic [CNT_W-1:0]  w_last_idx;
  logic [31:0]       w_nib_off;
  logic [31:0]       w_elem_mask;
  logic [7:0]        w_lane_mask;
  logic [DATA_W-1:0] w_elem_data;
  logic [NIBS-1:0]   w_elem_nmask;
  logic [DATA_W-1:0] w_word_data;
  logic [NIBS-1:0]   w_word_nmask;

  // Handshakes.
  // in_ready depends only on the buffer state and on out_ready.
  assign w_in_ready = !out_valid_q || bus.out_ready_i;
  assign w_accept   = bus.in_valid_i && w_in_ready;
  assign w_out_hs   = out_valid_q && bus.out_ready_i;

  // The first element of a word takes ew_i. Later elements reuse the latched width.
  assign w_ew_eff   = (cnt_q == '0) ? bus.ew_i : ew_q;
  assign w_last_idx = CNT_W'((NIBS >> w_ew_eff) - 1);
  assign w_complete = w_accept && ((cnt_q == w_last_idx) || bus.in_last_i);

  // Element placement: element k starts at nibble k * (nibbles per element).
  assign w_nib_off  = 32'(cnt_q) << w_ew_eff;

  // Element data mask and nibble-lane mask for the effective width
  always_comb begin
    w_elem_mask = 32'hFFFF_FFFF;
    w_lane_mask = 8'hFF;
    case (w_ew_eff)
      2'b00:   begin w_elem_mask = 32'h0000_000F; w_lane_mask = 8'h01; end
      2'b01:   begin w_elem_mask = 32'h0000_00FF; w_lane_mask = 8'h03; end
      2'b10:   begin w_elem_mask = 32'h0000_FFFF; w_lane_mask = 8'h0F; end
      default: begin w_elem_mask = 32'hFFFF_FFFF; w_lane_mask = 8'hFF; end
    endcase
  end

  assign w_elem_data  = DATA_W'(bus.in_data_i & w_elem_mask) << (w_nib_off << 2);
  assign w_elem_nmask = NIBS'(w_lane_mask) << w_nib_off;
  assign w_word_data  = acc_data_q  | w_elem_data;
  assign w_word_nmask = acc_nmask_q | w_elem_nmask;

  // Next-state: accumulate, hand completed words to the buffer, drain on handshake
  always_comb begin
    acc_data_d  = acc_data_q;
    acc_nmask_d = acc_nmask_q;
    cnt_d       = cnt_q;
    ew_d        = ew_q;
    out_data_d  = out_data_q;
    out_nmask_d = out_nmask_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (w_out_hs) begin
      out_valid_d = 1'b0;
    end

    // Accepting implies the buffer is empty or draining this cycle,
    // so a completed word may overwrite it without losing data.
    if (w_accept) begin
      ew_d = w_ew_eff;
      if (w_complete) begin
        acc_data_d  = '0;
        acc_nmask_d = '0;
        cnt_d       = '0;
        out_data_d  = w_word_data;
        out_nmask_d = w_word_nmask;
        out_last_d  = bus.in_last_i;
        out_valid_d = 1'b1;
      end else begin
        acc_data_d  = w_word_data;
        acc_nmask_d = w_word_nmask;
        cnt_d       = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_data_q  <= '0;
      acc_nmask_q <= '0;
      cnt_q       <= '0;
      ew_q        <= C_EW8;
      out_data_q  <= '0;
      out_nmask_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_data_q  <= acc_data_d;
      acc_nmask_q <= acc_nmask_d;
      cnt_q       <= cnt_d;
      ew_q        <= ew_d;
      out_data_q  <= out_data_d;
      out_nmask_q <= out_nmask_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_nmask_o = out_nmask_q;
  assign bus.out_last_o  = out_last_q;

`ifdef RVMV_PACKER_STATS_EN
  logic [15:0] stat_q, stat_d;

  // Saturating count of output handshakes
  always_comb begin
    stat_d = stat_q;
    if (w_out_hs && (stat_q != 16'hFFFF)) begin
      stat_d = stat_q + 16'd1;
    end
  end

  // Statistics register
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_words_o = stat_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rvmv_elem_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvmv_elem_packer
// Brief    : Directed and random stimulus for rvmv_elem_packer.
//            The bench model holds accepted elements in a queue. It builds each
//            word from that element list and tracks the one-deep output buffer.
// Revision : 1.0  initial release
// ============================================================================
module tb_rvmv_elem_packer;
  localparam int DATA_W = 32;
  localparam int NIBS   = DATA_W / 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rvmv_elem_packer_if #(.DATA_W(DATA_W)) bus();

`ifdef RVMV_PACKER_STATS_EN
  logic [15:0] stat_words;
`endif

  rvmv_elem_packer #(.DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef RVMV_PACKER_STATS_EN
    ,
    .stat_words_o (stat_words)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0]       m_elems[$];
  int                m_ew;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [NIBS-1:0]   m_nmask;
  logic              m_last;
  int                m_stat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("in_ready", 64'(bus.in_ready_o), 64'(!m_valid || bus.out_ready_i));
    chk("out_valid", 64'(bus.out_valid_o), 64'(m_valid));
    if (m_valid) begin
      chk("out_data", 64'(bus.out_data_o), 64'(m_data));
      chk("out_nmask", 64'(bus.out_nmask_o), 64'(m_nmask));
      chk("out_last", 64'(bus.out_last_o), 64'(m_last));
    end
`ifdef RVMV_PACKER_STATS_EN
    chk("stat_words", 64'(stat_words), 64'(m_stat));
`endif
  endtask

  // Apply one clock edge to the model using the current inputs
  task automatic model_edge();
    logic acc, hs;
    int   bits, npe, cap;
    logic [63:0] e;
    if (reset) begin
      m_elems.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_nmask = '0;
      m_last  = 1'b0;
      m_stat  = 0;
      return;
    end
    acc = bus.in_valid_i && (!m_valid || bus.out_ready_i);
    hs  = m_valid && bus.out_ready_i;
    if (hs && m_stat < 65535) m_stat++;
    if (hs) m_valid = 1'b0;
    if (acc) begin
      if (m_elems.size() == 0) m_ew = int'(bus.ew_i);
      m_elems.push_back(bus.in_data_i);
      bits = 4 << m_ew;
      npe  = 1 << m_ew;
      cap  = DATA_W / bits;
      if (m_elems.size() == cap || bus.in_last_i) begin
        m_data  = '0;
        m_nmask = '0;
        foreach (m_elems[k]) begin
          e = 64'(m_elems[k]) & ((64'd1 << bits) - 64'd1);
          m_data = m_data | DATA_W'(e << (k * bits));
          for (int n = 0; n < npe; n++) m_nmask[k*npe+n] = 1'b1;
        end
        m_valid = 1'b1;
        m_last  = bus.in_last_i;
        m_elems.delete();
      end
    end
  endtask

  // Called at a negedge. Checks outputs, drives inputs, advances one cycle
  // and returns at the following negedge.
  task automatic step(input logic v, input logic [31:0] d, input logic l,
                      input logic [1:0] ew, input logic ordy);
    compare_all();
    bus.in_valid_i  = v;
    bus.in_data_i   = d;
    bus.in_last_i   = l;
    bus.ew_i        = ew;
    bus.out_ready_i = ordy;
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.in_valid_i = 1'b0;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    reset = 1'b0;
    chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_out_data", 64'(bus.out_data_o), 64'd0);
    chk("rst_out_nmask", 64'(bus.out_nmask_o), 64'd0);
    chk("rst_out_last", 64'(bus.out_last_o), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = '0;
    bus.in_last_i   = 1'b0;
    bus.ew_i        = 2'b01;
    bus.out_ready_i = 1'b1;
    m_ew = 1;
    @(negedge clock);
    do_reset();

    // EW8, four elements, no last
    step(1, 32'h11, 0, 2'b01, 1);
    step(1, 32'h22, 0, 2'b01, 1);
    step(1, 32'h33, 0, 2'b01, 1);
    step(1, 32'h44, 0, 2'b01, 1);
    chk("ew8_valid", 64'(bus.out_valid_o), 64'd1);
    chk("ew8_data", 64'(bus.out_data_o), 64'h4433_2211);
    chk("ew8_nmask", 64'(bus.out_nmask_o), 64'hFF);
    chk("ew8_last", 64'(bus.out_last_o), 64'd0);
    step(0, 0, 0, 2'b01, 1);

    // EW4, eight elements, last on the eighth
    for (int i = 1; i <= 8; i++) step(1, 32'(i), (i == 8), 2'b00, 1);
    chk("ew4_data", 64'(bus.out_data_o), 64'h8765_4321);
    chk("ew4_nmask", 64'(bus.out_nmask_o), 64'hFF);
    chk("ew4_last", 64'(bus.out_last_o), 64'd1);
    step(0, 0, 0, 2'b00, 1);

    // EW16, a single element that is also the last element
    step(1, 32'hFFFF_BEEF, 1, 2'b10, 1);
    chk("ew16_data", 64'(bus.out_data_o), 64'h0000_BEEF);
    chk("ew16_nmask", 64'(bus.out_nmask_o), 64'h0F);
    chk("ew16_last", 64'(bus.out_last_o), 64'd1);
    step(0, 0, 0, 2'b10, 1);

    // EW32, three elements with a five-cycle downstream stall
    step(1, 32'hA1A1_A1A1, 0, 2'b11, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 32'hB2B2_B2B2, 0, 2'b11, 0);
      chk("stall_in_ready", 64'(bus.in_ready_o), 64'd0);
      chk("stall_data", 64'(bus.out_data_o), 64'hA1A1_A1A1);
    end
    step(1, 32'hB2B2_B2B2, 0, 2'b11, 1);
    chk("ew32_second", 64'(bus.out_data_o), 64'hB2B2_B2B2);
    step(1, 32'hC3C3_C3C3, 1, 2'b11, 1);
    chk("ew32_third", 64'(bus.out_data_o), 64'hC3C3_C3C3);
    chk("ew32_last", 64'(bus.out_last_o), 64'd1);
    step(0, 0, 0, 2'b11, 1);

    // Width change mid-word is ignored until the next word
    step(1, 32'hAA, 0, 2'b01, 1);
    step(1, 32'hBB, 0, 2'b01, 1);
    step(1, 32'hCC, 0, 2'b10, 1);
    step(1, 32'hDD, 0, 2'b10, 1);
    chk("ewlatch_data", 64'(bus.out_data_o), 64'hDDCC_BBAA);
    step(1, 32'h1234, 0, 2'b10, 1);
    step(1, 32'h5678, 0, 2'b10, 1);
    chk("ewnext_data", 64'(bus.out_data_o), 64'h5678_1234);
    chk("ewnext_nmask", 64'(bus.out_nmask_o), 64'hFF);
    step(0, 0, 0, 2'b10, 1);

    // Reset mid-word discards the partial word
    step(1, 32'h0A, 0, 2'b01, 1);
    step(1, 32'h0B, 0, 2'b01, 1);
    step(1, 32'h0C, 0, 2'b01, 1);
    do_reset();
    step(1, 32'h01, 0, 2'b01, 1);
    step(1, 32'h02, 0, 2'b01, 1);
    step(1, 32'h03, 0, 2'b01, 1);
    chk("post_rst_no_word", 64'(bus.out_valid_o), 64'd0);
    step(1, 32'h04, 0, 2'b01, 1);
    chk("post_rst_data", 64'(bus.out_data_o), 64'h0403_0201);
    step(0, 0, 0, 2'b01, 1);
    chk("post_rst_drained", 64'(bus.out_valid_o), 64'd0);
`ifdef RVMV_PACKER_STATS_EN
    chk("post_rst_stat", 64'(stat_words), 64'd1);
`endif

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) == 0,
             2'($urandom_range(0, 3)), $urandom_range(0, 9) < 7);
      end
    end
    compare_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rvmv_elem_packer.md
RVMV_ELEM_PACKER -- requirements
Module: rvmv_elem_packer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, output word width in bits; legal values are a power of two, at least 32.
REQ-002 SHALL have input `clock`, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have input `reset`, 1 bit, synchronous active-high reset.
REQ-004 SHALL have input `ew_i`, 2 bits, element width encoded as vew_e: EW4=00, EW8=01, EW16=10, EW32=11.
REQ-005 SHALL have input `in_valid_i`, 1 bit, element valid.
REQ-006 SHALL have output `in_ready_o`, 1 bit, element accepted when valid and ready are both high.
REQ-007 SHALL have input `in_data_i`, 32 bits, element value; only the low EW bits are used.
REQ-008 SHALL have input `in_last_i`, 1 bit, marks the final element of a stream.
REQ-009 SHALL have output `out_valid_o`, 1 bit, packed word valid.
REQ-010 SHALL have input `out_ready_i`, 1 bit, downstream accepts the word.
REQ-011 SHALL have output `out_data_o`, DATA_W bits, packed elements.
REQ-012 SHALL have output `out_nmask_o`, DATA_W/4 bits, one bit per nibble, set for each nibble written with element data.
REQ-013 SHALL have output `out_last_o`, 1 bit, word holds the final element of the stream.

Function
REQ-014 SHALL pack elements LSB-first: element k of a word occupies bits [(k+1)*EW-1 : k*EW], where EW = 4<<ew.
REQ-015 SHALL size each word at DATA_W/EW elements (8/4/2/1 for DATA_W=32 and EW4/8/16/32); the element counter wraps to 0 after each word is emitted.
REQ-016 SHALL latch `ew_i` only on acceptance of the first element of a word (counter==0); changes to `ew_i` at any later point in the word SHALL be ignored until the next word starts.
REQ-017 SHALL contain two registers: an accumulator (data, nibble mask, count) and an output buffer (data, nmask, last, valid).
REQ-018 SHALL drive `in_ready_o` = !out_valid_o || out_ready_i; this is a combinational path from `out_ready_i` and is the only one.
REQ-019 When an accepted element fills the word, or carries `in_last_i`=1, the completed word SHALL load into the output buffer on that edge, `out_valid_o` SHALL be high the next cycle, and the accumulator SHALL clear (latency of 1 cycle).
REQ-020 A partial word that ends on `in_last_i` SHALL leave its unwritten lanes zero with the matching nmask bits at 0.
REQ-021 A word that is both full and last SHALL set `out_last_o`=1 and set all nmask bits.
REQ-022 A simultaneous out handshake and a word completion in the same cycle SHALL replace the buffer with no bubble; an out handshake with no completion SHALL clear `out_valid_o`.
REQ-023 Output buffer fields SHALL stay stable while `out_valid_o`=1 and `out_ready_i`=0.
REQ-024 `in_valid_i` with `in_ready_o`=0 SHALL not change any state.

Reset
REQ-025 On `reset`=1 at a clock edge: `out_valid_o`=0, `out_data_o`=0, `out_nmask_o`=0, `out_last_o`=0, accumulator and counter=0, latched ew=EW8; `in_ready_o` SHALL then read 1.
REQ-026 Reset mid-word SHALL discard any partial accumulator content and any pending output word; no partial word is emitted afterwards.

Configuration
REQ-027 Macro RVMV_PACKER_STATS_EN defined: SHALL add output `stat_words_o` (16 bits), cleared by reset, incremented on each out handshake, saturating at 0xFFFF.
REQ-028 Macro RVMV_PACKER_STATS_EN undefined: the port and the counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 EW8, DATA_W=32, elements 0x11,0x22,0x33,0x44 with out_ready=1 -> one word 0x44332211, nmask 0xFF, last 0, valid on the cycle after the 4th element.
REQ-030 EW4, eight elements 0x1..0x8, last on the 8th -> 0x87654321, nmask 0xFF, last 1.
REQ-031 EW16, single element 0xBEEF with last=1 -> 0x0000BEEF, nmask 0x0F, last 1.
REQ-032 EW32 stream of 3 elements, out_ready held 0 for 5 cycles after the first word -> in_ready_o low while stalled; words emitted in order, each unchanged while stalled; no element is lost.
REQ-033 EW8, two elements accepted, `ew_i` switched to EW16, then two more elements -> packed as EW8 (0xDDCCBBAA for AA,BB,CC,DD); the next word uses EW16.
REQ-034 Reset asserted after 3 EW8 elements, then 4 new elements -> only the post-reset word is emitted; stat_words_o (if enabled) reads 1.
